// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter merging I-cache and D-cache block misses onto one DRAM bus.
// Enables are held until acknowledge, then a forced RELEASE/DONE/IDLE gap precedes the next grant.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int BLOCK  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [ADDR_W-1:0]              i_addr,
  input  logic                           i_read_req,
  output logic [BLOCK-1:0][WORD_W-1:0]   i_rdata,
  output logic                           i_done,
  input  logic [ADDR_W-1:0]              d_addr,
  input  logic [BLOCK-1:0][WORD_W-1:0]   d_wdata,
  input  logic                           d_read_req,
  input  logic                           d_write_req,
  output logic [BLOCK-1:0][WORD_W-1:0]   d_rdata,
  output logic                           d_done,
  output logic [ADDR_W-1:0]              bus_address_to_mem,
  output logic [BLOCK-1:0][WORD_W-1:0]   bus_data_to_mem,
  output logic                           bus_read_enable,
  output logic                           bus_write_enable,
  input  logic [BLOCK-1:0][WORD_W-1:0]   bus_data_from_mem,
  input  logic                           acknowledge_from_mem
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE, DONE} state_t;

  state_t                         state_q, state_d;
  logic                           last_d_q, last_d_d;
  logic                           gnt_d_q, gnt_d_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [BLOCK-1:0][WORD_W-1:0]   wdata_q, wdata_d;
  logic                           rd_en_q, rd_en_d;
  logic                           wr_en_q, wr_en_d;
  logic [BLOCK-1:0][WORD_W-1:0]   i_rdata_q, i_rdata_d;
  logic [BLOCK-1:0][WORD_W-1:0]   d_rdata_q, d_rdata_d;
  logic                           i_done_q, i_done_d;
  logic                           d_done_q, d_done_d;

  logic i_pend, d_pend, pick_d, pick_wr;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    gnt_d_d   = gnt_d_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_en_d   = rd_en_q;
    wr_en_d   = wr_en_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;

    i_pend  = i_read_req;
    d_pend  = d_read_req | d_write_req;
    // D wins when it is alone, or when both wait and I was served last
    pick_d  = d_pend && (!i_pend || !last_d_q);
    // A D request with both read and write high is a write
    pick_wr = pick_d && d_write_req;

    case (state_q)
      IDLE: begin
        if (i_pend || d_pend) begin
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
          addr_d   = pick_d ? d_addr : i_addr;
          wdata_d  = pick_d ? d_wdata : '0;
          rd_en_d  = !pick_wr;
          wr_en_d  = pick_wr;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (acknowledge_from_mem) begin
          if (!wr_en_q) begin
            if (gnt_d_q) d_rdata_d = bus_data_from_mem;
            else         i_rdata_d = bus_data_from_mem;
          end
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!acknowledge_from_mem) begin
          i_done_d = !gnt_d_q;
          d_done_d = gnt_d_q;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      gnt_d_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      gnt_d_q   <= gnt_d_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
    end
  end

  assign bus_address_to_mem = addr_q;
  assign bus_data_to_mem    = wdata_q;
  assign bus_read_enable    = rd_en_q;
  assign bus_write_enable   = wr_en_q;
  assign i_rdata            = i_rdata_q;
  assign d_rdata            = d_rdata_q;
  assign i_done             = i_done_q;
  assign d_done             = d_done_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter directly upstream of the DRAM bus interface.
- Merges the instruction-cache (port I) and data-cache (port D) block-miss traffic onto the single main-memory bus: bus_address_to_mem, bus_data_to_mem, bus_read_enable, bus_write_enable, bus_data_from_mem, acknowledge_from_mem.
- Holds the bus request stable until the memory acknowledges.
- Forces an idle gap so the interface's word/cycle counters return to 0.
- Returns a registered block plus a one-cycle done pulse to the winning port.

Parameters:
ADDR_W, 32, byte address width (matches DRAM_ADDRESS_SIZE)
WORD_W, 32, word width (matches DRAM_WORD_SIZE)
BLOCK, 4, words per block (matches DRAM_BLOCK_SIZE)

Ports:
clock  in  1  system clock; the only clock
reset  in  1  synchronous, active-high
i_addr  in  ADDR_W  port I block address
i_read_req  in  1  port I read request; level, held until i_done
i_rdata  out  BLOCK x WORD_W  port I returned block, registered
i_done  out  1  port I completion pulse
d_addr  in  ADDR_W  port D block address
d_wdata  in  BLOCK x WORD_W  port D write block
d_read_req  in  1  port D read request; level
d_write_req  in  1  port D write request; level
d_rdata  out  BLOCK x WORD_W  port D returned block, registered
d_done  out  1  port D completion pulse
bus_address_to_mem  out  ADDR_W  to the interface
bus_data_to_mem  out  BLOCK x WORD_W  to the interface
bus_read_enable  out  1  to the interface
bus_write_enable  out  1  to the interface
bus_data_from_mem  in  BLOCK x WORD_W  from the interface
acknowledge_from_mem  in  1  from the interface

Behaviour:
- Reset (one clock with reset=1):
  - state=IDLE, last_grant=D.
  - All bus outputs 0; i_done=d_done=0.
  - i_rdata and d_rdata cleared to 0.
  - An in-flight transaction is abandoned; masters must re-request.
- States: IDLE, BUSY, RELEASE, DONE.
- IDLE:
  - Pending = i_read_req for I; d_read_req|d_write_req for D.
  - Only one pending: grant it.
  - Both pending: grant the port that is not last_grant (round-robin).
  - On grant, register the address, write data and the read/write enable from the granted port, set last_grant, go to BUSY.
  - First enable-high cycle is the cycle after the request is seen in IDLE.
- D port with both read and write high: treated as a write. Read data is not updated.
- BUSY:
  - Address, data and the enable are held constant; master inputs are ignored from the grant onward.
  - On the first cycle acknowledge_from_mem=1:
    - If the transaction is a read, capture bus_data_from_mem into the granted port's rdata register.
    - Drop both enables on the next edge and go to RELEASE.
- RELEASE:
  - Enables stay 0.
  - Remain until acknowledge_from_mem=0 (at least 1 cycle), then go to DONE.
- DONE:
  - Granted port's done=1 for exactly this cycle; go to IDLE.
  - A master may drop its request in the done cycle. A request still high on the following IDLE cycle is a new transaction.
- Turnaround: minimum 3 cycles with enables low between consecutive transactions (RELEASE, DONE, IDLE).
- bus_read_enable and bus_write_enable are never high together. Both are 0 outside BUSY.
- rdata of a port changes only on its own read capture. Writes leave d_rdata unchanged.
- i_done and d_done are never high together.
- No timeout: BUSY waits indefinitely for the acknowledge.

Test Plan:
- Reset, then i_read_req=1, i_addr=0x100; memory acks after 10 cycles with block {1,2,3,4} -> bus_read_enable=1 from the cycle after the request; bus_address_to_mem=0x100 stable through BUSY; i_rdata={1,2,3,4}; i_done pulses once; d_done stays 0.
- d_write_req=1, d_addr=0x200, d_wdata={A,B,C,D} -> bus_write_enable=1 and bus_data_to_mem={A,B,C,D} until ack; d_rdata unchanged; d_done pulse.
- i_read_req and d_read_req asserted the same cycle after reset -> I granted first (last_grant=D at reset), then D. At least 3 enable-low cycles separate the two grants; i_done precedes d_done.
- Both ports held requesting for 4 transactions -> grants alternate I,D,I,D; no port is granted twice in a row while the other waits.
- acknowledge_from_mem held high for 3 cycles -> enables fall one cycle after ack rises; DONE only after ack falls; a single done pulse.
- Reset asserted during BUSY -> the next cycle all bus enables are 0, done outputs are 0, rdata is 0, state is IDLE; a fresh request is then served normally.
